mul8_seq_ctrl: RTL and testbench
================================

# mul8_seq_ctrl

Sequential 8x8 unsigned shift-and-add multiplier controller. It sequences the existing 8-bit-by-1-bit AND gate array (`And_8x1`) as its partial-product generator, one multiplier bit per clock. It accumulates partial products into a 16-bit product register. The block sits between a requesting unit (start/operands) and any consumer of the 16-bit product, with a simple ready/start/done handshake.

## Interface
- No parameters; widths fixed at 8x8 -> 16.
- `clk`  in  1  single system clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only in a cycle where `ready`=1.
- `a`  in  8  multiplicand; sampled on the accepting edge.
- `b`  in  8  multiplier; sampled on the accepting edge.
- `ready`  out  1  high only in IDLE.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; `p` is valid in that cycle.
- `p`  out  16  product; holds its value until the next DONE.

## Operation
- States: IDLE, RUN, DONE. Encoding is free but must be one-hot-safe; an illegal state goes to IDLE.
- IDLE with `start`=1:
  - latch `a` into A_reg;
  - load P_reg[15:0] = {8'h00, `b`};
  - set cnt = 0;
  - go to RUN.
- IDLE with `start`=0: stay in IDLE.
- RUN, each cycle:
  - pp = A_reg AND {8{P_reg[0]}}, produced by the `And_8x1` instance (`in8bit`=A_reg, `in1bit`=P_reg[0]).
  - sum[8:0] = P_reg[15:8] + pp (9-bit, carry kept).
  - P_reg <= {sum[8:0], P_reg[7:1]}.
  - cnt <= cnt + 1.
- RUN exit: when cnt == 7 on an edge, that edge performs the final step, loads the result register with the new P_reg value, and moves to DONE. cnt wraps to 0 and is don't-care afterwards.
- DONE: `done`=1 for exactly one cycle, then unconditionally go to IDLE.
- `start` during RUN or DONE is ignored, with no queuing; `a`/`b` changes are ignored then too.
- Arithmetic: unsigned only. The product always fits in 16 bits. No overflow case exists.

## Timing
- Reset values: state=IDLE, `ready`=1, `busy`=0, `done`=0, `p`=16'h0000; A_reg, P_reg and cnt cleared.
- Cycle numbering, with start accepted in cycle 0:
  - RUN in cycles 1-8;
  - DONE (`done`=1, `p` valid) in cycle 9;
  - IDLE (`ready`=1) in cycle 10.
- Throughput: one multiply per 10 cycles. Back-to-back `start` held high is re-accepted in cycle 10.
- `p` changes only on the edge entering DONE. It stays stable in IDLE and through the next operation's RUN cycles.
- `rst` asserted in any state, including mid-RUN:
  - next cycle is IDLE with all reset values, including `p`=0;
  - an in-flight operation is discarded and no `done` pulse is produced;
  - `rst` has priority over `start` on the same edge.
- `ready`, `busy` and `done` are decoded from registered state only. No combinational path exists from `start`, `a` or `b` to any output.

## Structure
- Shared package/header: state encoding constants (ST_IDLE, ST_RUN, ST_DONE), MUL_STEPS=8, and the width constants 8/16.
- The single natural sub-module is the existing `And_8x1` gate array (PNU_AND2-based), instantiated once for partial-product gating.
- The 9-bit adder stays inline; no separate adder module is required.

## Test plan
- After reset: `ready`=1, `busy`=0, `done`=0, `p`=0.
- `a`=13, `b`=11, `start` pulse -> `done` in cycle 9 with `p`=16'd143; `ready` returns in cycle 10.
- `a`=8'hFF, `b`=8'hFF -> `p`=16'hFE01.
- `a`=8'hA5, `b`=0 -> `p`=0.
- `a`=0, `b`=8'h5A -> `p`=0.
- Start 7x9, then assert `start` with `a`=2, `b`=3 in cycles 3 and 9 -> single `done` with `p`=63. Then hold `start` with 2x3 -> next `done` exactly 10 cycles later with `p`=6.
- Start 200x200, assert `rst` in cycle 5 -> IDLE next cycle, `p`=0, no `done`. A following 4x5 -> `p`=20 with standard latency.

Source files
------------

// File: rtl/mul8_seq_ctrl_pkg.sv
// mul8_seq_ctrl_pkg
//   Shared constants and types for the sequential 8x8 shift-and-add
//   multiplier controller.
//   - state_e   : one-hot FSM state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   - MUL_STEPS : number of RUN cycles, one per multiplier bit
//   - OP_W/PROD_W : operand and product widths
package mul8_seq_ctrl_pkg;

  localparam int OP_W      = 8;
  localparam int PROD_W    = 16;
  localparam int MUL_STEPS = 8;
  localparam int CNT_W     = 3;

  // Step index at which the final shift-add happens.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

  // One-hot encoding; any other pattern is illegal and recovers to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_DONE = 3'b100
  } state_e;

endpackage

// File: rtl/And_8x1.sv
// And_8x1
//   8-bit by 1-bit AND gate array: every bit of in8bit is gated by in1bit.
//   Used as the partial-product generator of the shift-and-add multiplier.
//   Each bit corresponds to one PNU_AND2 two-input AND cell of the original
//   gate array; here each cell is written as a plain 2-input AND.
//   Ports:
//     in8bit  [7:0] in  : multiplicand byte
//     in1bit        in  : current multiplier bit
//     out8bit [7:0] out : in8bit & {8{in1bit}}
module And_8x1 (
  input  logic [7:0] in8bit,
  input  logic       in1bit,
  output logic [7:0] out8bit
);

  for (genvar i = 0; i < 8; i++) begin : g_and2
    assign out8bit[i] = in8bit[i] & in1bit;
  end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl
//   Sequential 8x8 unsigned shift-and-add multiplier. One multiplier bit is
//   consumed per clock: 1 accept cycle, 8 RUN cycles, 1 DONE cycle.
//
//   Handshake: a request is taken on a rising edge where start=1 and ready=1;
//   a and b are sampled on that same edge. start/a/b are ignored whenever
//   ready=0. done is a one-cycle pulse and p is valid during it; p then holds
//   until the next DONE (or reset). ready/busy/done are registered and depend
//   only on FSM state, never combinationally on start/a/b.
//
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   synchronous active-high reset
//     start      in   request (accepted only while ready=1)
//     a   [7:0]  in   multiplicand
//     b   [7:0]  in   multiplier
//     ready      out  high in IDLE
//     busy       out  high in RUN and DONE
//     done       out  one-cycle completion pulse
//     p   [15:0] out  product register
//     dbg_state  out  current FSM state, for observation only
module mul8_seq_ctrl
  import mul8_seq_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] p,
  output state_e            dbg_state
);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     a_reg_q, a_reg_d;
  logic [PROD_W-1:0]   p_reg_q, p_reg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   p_q, p_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [OP_W-1:0]     pp;
  logic [OP_W:0]       sum;
  logic [PROD_W-1:0]   p_reg_shift;

  // Partial product: multiplicand gated by the current low multiplier bit.
  And_8x1 u_and_8x1 (
    .in8bit  (a_reg_q),
    .in1bit  (p_reg_q[0]),
    .out8bit (pp)
  );

  // Upper half plus partial product; the carry becomes bit 15 after the shift.
  assign sum         = {1'b0, p_reg_q[PROD_W-1:OP_W]} + {1'b0, pp};
  assign p_reg_shift = {sum, p_reg_q[OP_W-1:1]};

  always_comb begin
    state_d = state_q;
    a_reg_d = a_reg_q;
    p_reg_d = p_reg_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_reg_d = a;
          p_reg_d = {{OP_W{1'b0}}, b};
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        p_reg_d = p_reg_shift;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          p_d     = p_reg_shift;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next-state decode, so they
    // line up with the state they describe.
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_RUN) || (state_d == ST_DONE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_reg_q <= '0;
      p_reg_q <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_reg_q <= a_reg_d;
      p_reg_q <= p_reg_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign p         = p_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
module tb_mul8_seq_ctrl;
  import mul8_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] p;
  state_e      dbg_state;

  int errors = 0;
  int checks = 0;

  // Scoreboard: expected products in issue order.
  logic [15:0] exp_q[$];
  // Product the p output is expected to be holding.
  logic [15:0] last_p;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mul8_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .p         (p),
    .dbg_state (dbg_state)
  );

  // Advance one cycle; outputs are sampled 1 time unit after the edge and
  // inputs for the new cycle are driven at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer multiply.
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int r;
    r = int'(x) * int'(y);
    return r[15:0];
  endfunction

  // ---------------- driver: one full multiply ----------------
  // Cycle 0 is the current cycle (IDLE). Start/a/b are randomized during
  // RUN/DONE, which must be ignored.
  task automatic do_mul(input logic [7:0] aa, input logic [7:0] bb, input string name);
    logic [15:0] exp_p;
    logic [18:0] want;
    exp_p = 16'h0;
    start = 1'b1;
    a     = aa;
    b     = bb;
    exp_q.push_back(ref_mul(aa, bb));
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept_ready: got ready=%b, want 1", name, ready);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 9) exp_p = exp_q.pop_front();
      if (k <= 8)      want = {3'b010, last_p};
      else if (k == 9) want = {3'b011, exp_p};
      else             want = {3'b100, exp_p};
      checks++;
      if ({ready, busy, done, p} !== want) begin
        errors++;
        $display("FAIL %s_cycle%0d: got r=%b b=%b d=%b p=%h, want r=%b b=%b d=%b p=%h (a=%0d b=%0d)",
                 name, k, ready, busy, done, p, want[18], want[17], want[16], want[15:0], aa, bb);
      end
      start = (k <= 9) ? 1'($urandom_range(0, 1)) : 1'b0;
      a     = 8'($urandom);
      b     = 8'($urandom);
    end
    last_p = exp_p;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'h0; b = 8'h0;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({ready, busy, done, p} !== {3'b100, 16'h0000}) begin
      errors++;
      $display("FAIL reset_outputs: got r=%b b=%b d=%b p=%h, want r=1 b=0 d=0 p=0000",
               ready, busy, done, p);
    end
    step();
    checks++;
    if ({ready, busy, done, p} !== {3'b100, 16'h0000}) begin
      errors++;
      $display("FAIL reset_idle_hold: got r=%b b=%b d=%b p=%h, want r=1 b=0 d=0 p=0000",
               ready, busy, done, p);
    end
    last_p = 16'h0000;
  endtask

  task automatic test_directed();
    do_mul(8'd13,  8'd11,  "mul_13x11");
    do_mul(8'hFF,  8'hFF,  "mul_ffxff");
    do_mul(8'hA5,  8'h00,  "mul_a5x0");
    do_mul(8'h00,  8'h5A,  "mul_0x5a");
    do_mul(8'h01,  8'hFF,  "mul_1xff");
    do_mul(8'h80,  8'h80,  "mul_80x80");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      do_mul(8'($urandom), 8'($urandom), "mul_rand");
    end
  endtask

  // 7x9 with ignored starts in cycles 3 and 9, then start held so 2x3 is
  // taken in cycle 10 and completes in cycle 19.
  task automatic test_back_to_back();
    logic [18:0] want;
    start = 1'b1; a = 8'd7; b = 8'd9;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept_ready: got ready=%b, want 1", ready);
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k <= 8)       want = {3'b010, last_p};
      else if (k == 9)  want = {3'b011, 16'd63};
      else if (k == 10) want = {3'b100, 16'd63};
      else if (k <= 18) want = {3'b010, 16'd63};
      else if (k == 19) want = {3'b011, 16'd6};
      else              want = {3'b100, 16'd6};
      checks++;
      if ({ready, busy, done, p} !== want) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got r=%b b=%b d=%b p=%h, want r=%b b=%b d=%b p=%h",
                 k, ready, busy, done, p, want[18], want[17], want[16], want[15:0]);
      end
      start = (k == 3) || (k == 9) || (k >= 10 && k < 20);
      a     = start ? 8'd2 : 8'($urandom);
      b     = start ? 8'd3 : 8'($urandom);
    end
    start  = 1'b0;
    last_p = 16'd6;
  endtask

  // 200x200 aborted by reset in cycle 5; then reset together with start in
  // IDLE must win; then a normal 4x5.
  task automatic test_reset_mid_run();
    logic [18:0] want;
    start = 1'b1; a = 8'd200; b = 8'd200;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k <= 5) want = {3'b010, last_p};
      else        want = {3'b100, 16'h0000};
      checks++;
      if ({ready, busy, done, p} !== want) begin
        errors++;
        $display("FAIL rst_run_cycle%0d: got r=%b b=%b d=%b p=%h, want r=%b b=%b d=%b p=%h",
                 k, ready, busy, done, p, want[18], want[17], want[16], want[15:0]);
      end
      rst   = (k == 5) || (k == 8);
      start = (k == 8);
      a     = 8'd9;
      b     = 8'd9;
    end
    rst    = 1'b0;
    start  = 1'b0;
    last_p = 16'h0000;
    do_mul(8'd4, 8'd5, "mul_after_rst");
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    rst = 1'b1; start = 1'b0; a = 8'h0; b = 8'h0;
    last_p = 16'h0000;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
